// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V widths and the retire trace record (seq field with TRACE_SEQNUM_EN)
package riscv_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      reg_addr;
        logic [XLEN-1:0] reg_data;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
        logic            mem_wrt;
`ifdef TRACE_SEQNUM_EN
        logic [31:0]     seq;
`endif
    } retire_rec_t;

endpackage

// File: rtl/retire_trace_serializer_if.sv
// rtl/retire_trace_serializer_if.sv - valid/ready record stream between the trace buffer and its consumer
interface retire_trace_serializer_if;
    import riscv_pkg::*;

    logic        rec_valid;
    logic        rec_ready;
    retire_rec_t rec;

    modport master (output rec_valid, output rec, input rec_ready);
    modport slave  (input rec_valid, input rec, output rec_ready);

endinterface

// File: rtl/retire_fifo.sv
// rtl/retire_fifo.sv - Depth-entry record buffer, up to two pushes and one pop per cycle
module retire_fifo
    import riscv_pkg::*;
#(
    parameter int Depth = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [1:0]               push_cnt_i,
    input  retire_rec_t              push_rec_i [2],
    retire_trace_serializer_if.master deq,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    retire_rec_t   mem_q [Depth];
    retire_rec_t   mem_d [Depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop;

    // Lane 0 is always the older record; the caller compacts a lone slot-1 record onto it.
    always_comb begin
        mem_d = mem_q;
        pop   = deq.rec_valid & deq.rec_ready;
        if (push_cnt_i != 2'd0) mem_d[wr_ptr_q] = push_rec_i[0];
        if (push_cnt_i == 2'd2) mem_d[wr_ptr_q + AW'(1)] = push_rec_i[1];
        wr_ptr_d = wr_ptr_q + AW'(push_cnt_i);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push_cnt_i) - CW'(pop);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // Head is gated so an empty buffer shows an all-zero record.
    assign deq.rec_valid = (count_q != '0);
    assign deq.rec       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o       = count_q;

endmodule

// File: rtl/retire_trace_serializer.sv
// rtl/retire_trace_serializer.sv - serializes dual-issue retire records into a one-per-cycle stream (TRACE_SEQNUM_EN adds seq)
module retire_trace_serializer
    import riscv_pkg::*;
#(
    parameter int IssueWidth       = 2,
    parameter int Depth            = 8,
    parameter int AlmostFullMargin = 2
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            update_i   [IssueWidth],
    input  logic [XLEN-1:0] pc_i       [IssueWidth],
    input  logic [XLEN-1:0] instr_i    [IssueWidth],
    input  logic [4:0]      reg_addr_i [IssueWidth],
    input  logic [XLEN-1:0] reg_data_i [IssueWidth],
    input  logic [XLEN-1:0] mem_addr_i [IssueWidth],
    input  logic [XLEN-1:0] mem_data_i [IssueWidth],
    input  logic            mem_wrt_i  [IssueWidth],
    output logic            rec_valid_o,
    input  logic            rec_ready_i,
    output retire_rec_t     rec_o,
    output logic            almost_full_o,
    output logic            overflow_o,
    output logic [63:0]     retired_cnt_o
);
    localparam int CW = $clog2(Depth) + 1;

    logic [CW-1:0] count;
    logic [CW-1:0] n_valid;
    logic [CW-1:0] free;
    logic          pop;
    logic [1:0]    push_cnt;
    retire_rec_t   slot_rec [2];
    retire_rec_t   push_rec [2];
    logic          overflow_q, overflow_d;
    logic [63:0]   retired_cnt_q, retired_cnt_d;

    retire_trace_serializer_if deq_if ();

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            slot_rec[i]          = '0;
            slot_rec[i].pc       = pc_i[i];
            slot_rec[i].instr    = instr_i[i];
            slot_rec[i].reg_addr = reg_addr_i[i];
            slot_rec[i].reg_data = reg_data_i[i];
            slot_rec[i].mem_addr = mem_addr_i[i];
            slot_rec[i].mem_data = mem_data_i[i];
            slot_rec[i].mem_wrt  = mem_wrt_i[i];
        end
        push_rec[0] = update_i[0] ? slot_rec[0] : slot_rec[1];
        push_rec[1] = slot_rec[1];
`ifdef TRACE_SEQNUM_EN
        push_rec[0].seq = retired_cnt_q[31:0];
        push_rec[1].seq = retired_cnt_q[31:0] + 32'd1;
`endif
    end

    // A same-cycle pop frees its entry for this cycle's pushes; excess records are dropped in slot order.
    always_comb begin
        pop           = deq_if.rec_valid & rec_ready_i;
        n_valid       = CW'(update_i[0]) + CW'(update_i[1]);
        free          = CW'(Depth) - count + CW'(pop);
        overflow_d    = overflow_q;
        push_cnt      = n_valid[1:0];
        if (n_valid > free) begin
            push_cnt   = free[1:0];
            overflow_d = 1'b1;
        end
        retired_cnt_d = retired_cnt_q + 64'(push_cnt);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            overflow_q    <= 1'b0;
            retired_cnt_q <= '0;
        end else begin
            overflow_q    <= overflow_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    retire_fifo #(.Depth(Depth)) u_fifo (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .push_cnt_i (push_cnt),
        .push_rec_i (push_rec),
        .deq        (deq_if),
        .count_o    (count)
    );

    assign deq_if.rec_ready = rec_ready_i;
    assign rec_valid_o      = deq_if.rec_valid;
    assign rec_o            = deq_if.rec;
    assign almost_full_o    = (CW'(Depth) - count) <= CW'(AlmostFullMargin);
    assign overflow_o       = overflow_q;
    assign retired_cnt_o    = retired_cnt_q;

endmodule
